// File: rtl/shabal_inverse_permutation.sv
// Sequential inverse of the Shabal keyed permutation P(M,C): recovers the
// original (A, B) from a permuted state, undoing one forward step per clock.
module shabal_inverse_permutation (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [383:0] a_in,
  input  logic [511:0] b_in,
  input  logic [511:0] c_in,
  input  logic [511:0] m_in,
  output logic         busy,
  output logic         out_valid,
  output logic [383:0] a_out,
  output logic [511:0] b_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_STEP,
    S_UNROT
  } state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [5:0]   r_k;
  logic         r_busy;
  logic         r_out_valid;
  logic [383:0] r_a_out;
  logic [511:0] r_b_out;

  logic [31:0]  r_a [12];
  logic [31:0]  r_b [16];
  logic [31:0]  r_c [16];
  logic [31:0]  r_m [16];

  logic [3:0]   w_i;
  logic [3:0]   w_x;
  logic [3:0]   w_p;
  logic [31:0]  w_ax;
  logic [31:0]  w_ap;
  logic [31:0]  w_bi;
  logic [31:0]  w_t;
  logic [31:0]  w_u_inv;
  logic [31:0]  w_rot;
  logic [31:0]  w_v;
  logic [31:0]  w_a_new;
  logic [31:0]  w_b_nrot;
  logic [31:0]  w_b_new;
  logic [383:0] w_a_pack;
  logic [511:0] w_b_pack;

  // Step indices: i = k%16, x = k%12, p = (k+11)%12 for k in 0..47.
  assign w_i = r_k[3:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_x = r_k[3:0];
    if (r_k >= 6'd36)      w_x = 4'(r_k - 6'd36);
    else if (r_k >= 6'd24) w_x = 4'(r_k - 6'd24);
    else if (r_k >= 6'd12) w_x = 4'(r_k - 6'd12);
  end

  assign w_p  = (w_x == 4'd0) ? 4'd11 : w_x - 4'd1;
  assign w_ax = r_a[w_x];
  assign w_ap = r_a[w_p];
  assign w_bi = r_b[w_i];

  // Strip the forward XOR mask, then undo U (x3) with the inverse of 3 mod 2^32.
  assign w_t      = w_ax ^ r_m[w_i] ^ r_b[w_i + 4'd13]
                  ^ (r_b[w_i + 4'd9] & ~r_b[w_i + 4'd6]);
  assign w_u_inv  = w_t * 32'hAAAA_AAAB;
  assign w_rot    = {w_ap[16:0], w_ap[31:17]};
  assign w_v      = (w_rot << 2) + w_rot;
  assign w_a_new  = w_u_inv ^ w_v ^ r_c[4'd8 - w_i];
  assign w_b_nrot = ~(w_bi ^ w_ax);
  assign w_b_new  = {w_b_nrot[0], w_b_nrot[31:1]};

  always_comb begin
    w_a_pack = '0;
    w_b_pack = '0;
    for (int w = 0; w < 12; w++) w_a_pack[32*w +: 32] = r_a[w];
    for (int w = 0; w < 16; w++) w_b_pack[32*w +: 32] = {r_b[w][16:0], r_b[w][31:17]};
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SUB;
      S_SUB:   w_next_state = S_STEP;
      S_STEP:  if (r_k == 6'd0) w_next_state = S_UNROT;
      S_UNROT: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_k         <= 6'd0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_a_out     <= '0;
      r_b_out     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k         <= 6'd47;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        S_STEP: begin
          if (r_k != 6'd0) r_k <= r_k - 6'd1;
        end
        S_UNROT: begin
          r_a_out     <= w_a_pack;
          r_b_out     <= w_b_pack;
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the working A/B/C/M words are fully loaded on every accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          for (int w = 0; w < 12; w++) r_a[w] <= a_in[32*w +: 32];
          for (int w = 0; w < 16; w++) begin
            r_b[w] <= b_in[32*w +: 32];
            r_c[w] <= c_in[32*w +: 32];
            r_m[w] <= m_in[32*w +: 32];
          end
        end
      end
      S_SUB: begin
        for (int w = 0; w < 12; w++)
          r_a[w] <= r_a[w] - r_c[4'(w + 3)] - r_c[4'(w + 15)] - r_c[4'(w + 27)];
      end
      S_STEP: begin
        r_a[w_x] <= w_a_new;
        r_b[w_i] <= w_b_new;
      end
      S_UNROT: begin
        for (int w = 0; w < 16; w++) r_b[w] <= {r_b[w][16:0], r_b[w][31:17]};
      end
      default: ;
    endcase
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign a_out     = r_a_out;
  assign b_out     = r_b_out;

endmodule

// File: tb/tb_shabal_inverse_permutation.sv
// Bench for shabal_inverse_permutation: round trips through a forward P model,
// with a cycle-level expectation checked on every falling edge.
module tb_shabal_inverse_permutation;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [383:0] a_in;
  logic [511:0] b_in;
  logic [511:0] c_in;
  logic [511:0] m_in;
  logic         busy;
  logic         out_valid;
  logic [383:0] a_out;
  logic [511:0] b_out;

  always #5 clk = ~clk;

  shabal_inverse_permutation dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .m_in      (m_in),
    .busy      (busy),
    .out_valid (out_valid),
    .a_out     (a_out),
    .b_out     (b_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Forward Shabal permutation P(M,C) on (A,B).
  function automatic void fwd(input logic [383:0] ai, input logic [511:0] bi,
                              input logic [511:0] ci, input logic [511:0] mi,
                              output logic [383:0] ao, output logic [511:0] bo);
    logic [31:0] a [12];
    logic [31:0] b [16];
    logic [31:0] c [16];
    logic [31:0] m [16];
    logic [31:0] v;
    logic [31:0] u;
    int i, x, p;
    for (int w = 0; w < 12; w++) a[w] = ai[32*w +: 32];
    for (int w = 0; w < 16; w++) begin
      b[w] = rotl(bi[32*w +: 32], 17);
      c[w] = ci[32*w +: 32];
      m[w] = mi[32*w +: 32];
    end
    for (int j = 0; j < 48; j++) begin
      i = j % 16;
      x = j % 12;
      p = (j + 11) % 12;
      v = rotl(a[p], 15) * 32'd5;
      u = (a[x] ^ v ^ c[(24 - i) % 16]) * 32'd3;
      a[x] = u ^ b[(i + 13) % 16] ^ (b[(i + 9) % 16] & ~b[(i + 6) % 16]) ^ m[i];
      b[i] = ~rotl(b[i], 1) ^ a[x];
    end
    for (int j = 0; j < 36; j++) a[j % 12] = a[j % 12] + c[(j + 3) % 16];
    for (int w = 0; w < 12; w++) ao[32*w +: 32] = a[w];
    for (int w = 0; w < 16; w++) bo[32*w +: 32] = b[w];
  endfunction

  function automatic logic [383:0] rnd384();
    logic [383:0] r;
    for (int w = 0; w < 12; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  // Expected interface behaviour: a job lasts 50 edges after acceptance.
  logic [383:0] stim_a;
  logic [511:0] stim_b;
  bit           stim_known;
  bit           m_busy  = 1'b0;
  bit           m_ov    = 1'b0;
  bit           m_known = 1'b1;
  logic [383:0] m_a     = '0;
  logic [511:0] m_b     = '0;
  logic [383:0] m_exp_a;
  logic [511:0] m_exp_b;
  bit           m_exp_known;
  int           m_cnt   = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_ov    = 1'b0;
      m_known = 1'b1;
      m_a     = '0;
      m_b     = '0;
      m_cnt   = 0;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == 50) begin
        m_busy  = 1'b0;
        m_ov    = 1'b1;
        m_known = m_exp_known;
        m_a     = m_exp_a;
        m_b     = m_exp_b;
      end
    end else if (start) begin
      m_busy      = 1'b1;
      m_ov        = 1'b0;
      m_cnt       = 0;
      m_exp_a     = stim_a;
      m_exp_b     = stim_b;
      m_exp_known = stim_known;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 512'(busy), 512'(m_busy));
      check("out_valid", 512'(out_valid), 512'(m_ov));
      if (m_known) begin
        check("a_out", 512'(a_out), 512'(m_a));
        check("b_out", b_out, m_b);
      end
    end
  end

  // One job: drive P(orig) with the same C/M, optionally poke start or rst mid-run.
  task automatic run(input logic [383:0] oa, input logic [511:0] ob,
                     input logic [511:0] c, input logic [511:0] m,
                     input bit busy_poke, input bit rst_poke);
    logic [383:0] fa;
    logic [511:0] fb;
    int lat;
    fwd(oa, ob, c, m, fa, fb);
    @(negedge clk);
    a_in = fa; b_in = fb; c_in = c; m_in = m;
    stim_a = oa; stim_b = ob; stim_known = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ov_clear_on_accept", 512'(out_valid), 512'(0));
    lat = 0;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy_poke && lat == 9) begin
        a_in = ~a_in; b_in = ~b_in; c_in = rnd512(); m_in = rnd512();
        stim_a = ~oa; stim_b = ~ob;
        start = 1'b1;
      end
      if (busy_poke && lat == 10) start = 1'b0;
      if (rst_poke && lat == 19) rst = 1'b1;
      if (rst_poke && lat == 20) begin
        rst = 1'b0;
        check("rst_mid_busy", 512'(busy), 512'(0));
        check("rst_mid_ov", 512'(out_valid), 512'(0));
        check("rst_mid_a", 512'(a_out), 512'(0));
        check("rst_mid_b", b_out, 512'(0));
        return;
      end
      if (out_valid) break;
    end
    check("latency", 512'(lat), 512'(50));
    check("rt_a", 512'(a_out), 512'(oa));
    check("rt_b", b_out, ob);
  endtask

  initial begin
    logic [383:0] pa;
    logic [383:0] ra;
    logic [511:0] rb;
    int lat;
    rst = 1'b1; start = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; m_in = '0;
    stim_a = '0; stim_b = '0; stim_known = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", 512'(busy), 512'(0));
    check("reset_ov", 512'(out_valid), 512'(0));
    check("reset_a", 512'(a_out), 512'(0));
    check("reset_b", b_out, 512'(0));
    chk_en = 1'b1;

    run('0, '0, '0, '0, 1'b0, 1'b0);

    // Hand-built state: C=M=B=0, A[11]=3 so step k=47 sees t=3.
    @(negedge clk);
    pa = 384'(32'd3) << (32 * 11);
    a_in = pa; b_in = '0; c_in = '0; m_in = '0;
    stim_known = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("probe_a11", 512'(dut.r_a[11]), 512'(32'h0000_0001));
    check("probe_b15", 512'(dut.r_b[15]), 512'(32'h7FFF_FFFE));
    lat = 2;
    while (lat < 60 && !out_valid) begin
      @(posedge clk); #1;
      lat++;
    end
    check("probe_latency", 512'(lat), 512'(50));
    fwd(a_out, b_out, '0, '0, ra, rb);
    check("probe_fwd_a", 512'(ra), 512'(pa));
    check("probe_fwd_b", rb, 512'(0));

    run(rnd384(), rnd512(), rnd512(), rnd512(), 1'b1, 1'b0);
    run(rnd384(), rnd512(), rnd512(), rnd512(), 1'b0, 1'b1);
    run(rnd384(), rnd512(), rnd512(), rnd512(), 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++)
      run(rnd384(), rnd512(), rnd512(), rnd512(), 1'b0, 1'b0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/shabal_inverse_permutation.md
# shabal_inverse_permutation

Sequential inverse of the Shabal keyed permutation P(M,C): it takes a permuted state (A, B) together with the C and M words used in the forward pass, and recovers the original (A, B). It undoes one permutation step per clock, running the forward step equations backwards. It sits beside the forward permutation datapath and is used for self-check of the forward core and for known-answer regression of stored states.

## Interface
- No parameters; word width is fixed at 32 bits and the step count at 48 (3 rounds × 16).
- `clk  in  1` — single clock; everything is on the rising edge.
- `rst  in  1` — reset, synchronous and active-high.
- `start  in  1` — request; sampled only in IDLE.
- `a_in  in  384` — permuted A[0..11]; A[w] = a_in[32w+31:32w].
- `b_in  in  512` — permuted B[0..15], same packing.
- `c_in  in  512` — C[0..15] used by the forward pass.
- `m_in  in  512` — M[0..15] used by the forward pass.
- `busy  out  1` — high from the cycle after start is accepted until the result is written.
- `out_valid  out  1` — level; high while a_out/b_out hold a finished result.
- `a_out  out  384` — recovered A, same packing.
- `b_out  out  512` — recovered B, same packing.

## Operation
- States: IDLE, SUB, STEP, UNROT.
- IDLE, start=1: load A←a_in, B←b_in, C←c_in, M←m_in. Set k←47, busy←1, out_valid←0, then go to SUB.
- SUB (1 cycle): undo the 36 final additions, all words in parallel.
  - A[w] ← A[w] − C[(w+3)%16] − C[(w+15)%16] − C[(w+27)%16], all mod 2^32.
  - Go to STEP.
- STEP (48 cycles, k = 47 down to 0). Let i = k%16, x = k%12, p = (k+11)%12.
  - t = A[x] ^ M[i] ^ B[(i+13)%16] ^ (B[(i+9)%16] & ~B[(i+6)%16])
  - A[x] ← (t × 0xAAAAAAAB mod 2^32) ^ ((rotl(A[p],15) × 5) mod 2^32) ^ C[(24−i)%16]
  - B[i] ← rotr(~(B[i] ^ A[x]), 1), using the pre-update A[x].
  - All right-hand sides read the current-cycle register values.
  - 0xAAAAAAAB is the inverse of 3 mod 2^32. Multiplying by 5 is implemented as (v<<2)+v.
  - When k=0: go to UNROT. Otherwise k←k−1.
- UNROT (1 cycle): B[i] ← rotr(B[i],17) for all i. Copy A, B to a_out, b_out. Set out_valid←1, busy←0, go to IDLE.
- start while busy is ignored and has no side effects.
- start in IDLE while out_valid=1: accepted; out_valid clears on the same edge. a_out/b_out keep the old values until overwritten.
- rst at any cycle, including mid-STEP: state←IDLE, busy←0, out_valid←0, a_out←0, b_out←0, k←0. The internal A/B/C/M registers are don't-care.
- Reset values: busy=0, out_valid=0, a_out=0, b_out=0.

## Timing
- Edge E0: start sampled in IDLE. E1: SUB. E2..E49: 48 STEP updates. E50: UNROT; out_valid=1 after E50.
- Latency is 50 clocks from start acceptance to out_valid. Throughput is one result per 51 clocks, with start accepted on the edge after out_valid rises.
- busy is high after E0 through E49 and low after E50.
- Single-cycle critical path: one 32×32 constant multiply (shift-add of 0xAAAAAAAB), one shift-add, and XORs. No multicycle paths.

## Test plan
- Round trip, zero vector: A=B=C=M=0. Run through the golden forward P model, feed the result in with the same C, M. Required: a_out=0, b_out=0, out_valid exactly 50 cycles after start.
- Round trip, random: 1000 random (A,B,C,M) sets through the forward model and back. Required: a_out/b_out bit-exact to the originals every time.
- Single-step inverse constant: with forward-model state where A[x] step input t=0x00000003, check A after step k=47. Required: the U⁻¹ term equals 0x00000001 (probe the internal A[11] after E2).
- Start while busy: pulse start again at E10 with different inputs. Required: it is ignored; the result still matches the first inputs at E50.
- Reset mid-operation: assert rst at E20 for 1 cycle. Required: after that edge busy=0, out_valid=0, a_out=0, b_out=0. A fresh start then yields the correct result 50 cycles later.
- Back-to-back: assert start on the first cycle out_valid=1. Required: out_valid drops on that edge and the second result appears 50 cycles later, correct.
